// File: rtl/data_memory_sync.sv
// data_memory_sync: parametrised data memory for the load/store path.
//
// After reset the block sweeps every word to zero (DEPTH edges) with
// mem_ready low, then accepts one request per cycle. Reads are registered
// (1-cycle latency, mem_rvalid strobe). Addresses with any bit set above the
// index field are rejected with a one-cycle mem_err pulse.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   mem_req    in   request strobe
//   mem_we     in   1 = write, 0 = read
//   mem_addr   in   word address (ADDR_W bits)
//   mem_wdata  in   write data (DATA_W bits)
//   mem_ready  out  block accepts a request this cycle
//   mem_rvalid out  one-cycle pulse, mem_rdata/mem_err valid
//   mem_rdata  out  registered read data, held until the next accepted read
//   mem_err    out  one-cycle pulse, accepted request was out of range
module data_memory_sync #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned IDX_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic              mem_ready,
  output logic              mem_rvalid,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_err
);

  localparam int unsigned DEPTH = 2 ** IDX_W;
  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(DEPTH - 1);

  typedef enum logic {StClear, StReady} state_e;

  state_e            r_state;
  state_e            w_state_next;
  logic [IDX_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic              r_rvalid;
  logic              r_err;
  logic [DATA_W-1:0] r_rdata;

  logic              w_in_range;
  logic [IDX_W-1:0]  w_idx;
  logic              w_accept;
  logic              w_mem_we;
  logic [IDX_W-1:0]  w_mem_idx;
  logic [DATA_W-1:0] w_mem_wdata;

  // With no bits above the index field every address is in range.
  if (IDX_W < ADDR_W) begin : g_range
    assign w_in_range = (mem_addr[ADDR_W-1:IDX_W] == '0);
  end else begin : g_no_range
    assign w_in_range = 1'b1;
  end

  assign w_idx      = mem_addr[IDX_W-1:0];
  assign mem_ready  = (r_state == StReady);
  assign w_accept   = mem_req && mem_ready;
  assign mem_rvalid = r_rvalid;
  assign mem_err    = r_err;
  assign mem_rdata  = r_rdata;

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StClear: if (r_cnt == LastIdx) w_state_next = StReady;
      StReady: w_state_next = StReady;
      default: w_state_next = StClear;
    endcase
  end

  // Single array write port shared by the clear sweep and accepted writes.
  always_comb begin
    w_mem_we    = 1'b0;
    w_mem_idx   = w_idx;
    w_mem_wdata = mem_wdata;
    if (!rst) begin
      if (r_state == StClear) begin
        w_mem_we    = 1'b1;
        w_mem_idx   = r_cnt;
        w_mem_wdata = '0;
      end else if (w_accept && mem_we && w_in_range) begin
        w_mem_we = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_mem_idx] <= w_mem_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= StClear;
      r_cnt    <= '0;
      r_rvalid <= 1'b0;
      r_err    <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_state  <= w_state_next;
      if (r_state == StClear) begin
        r_cnt <= r_cnt + IDX_W'(1);
      end
      r_rvalid <= w_accept && !mem_we;
      r_err    <= w_accept && !w_in_range;
      // Read samples the array before any same-edge write lands.
      if (w_accept && !mem_we) begin
        r_rdata <= w_in_range ? r_mem[w_idx] : '0;
      end
    end
  end

endmodule

// File: tb/tb_data_memory_sync.sv
module tb_data_memory_sync;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       mem_req = 1'b0;
  logic       mem_we = 1'b0;
  logic [7:0] mem_addr = '0;
  logic [7:0] mem_wdata = '0;
  logic       mem_ready;
  logic       mem_rvalid;
  logic [7:0] mem_rdata;
  logic       mem_err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  data_memory_sync #(
    .DATA_W(8),
    .ADDR_W(8),
    .IDX_W (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .mem_rvalid(mem_rvalid),
    .mem_rdata (mem_rdata),
    .mem_err   (mem_err)
  );

  typedef struct {
    logic       req;
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic       rvalid;
    logic       err;
    logic [7:0] rdata;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic req, input logic we, input logic [7:0] addr,
                     input logic [7:0] wdata, input logic rvalid, input logic err,
                     input logic [7:0] rdata);
    vec_t v;
    v.req = req; v.we = we; v.addr = addr; v.wdata = wdata;
    v.rvalid = rvalid; v.err = err; v.rdata = rdata;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic req, input logic we, input logic [7:0] addr,
                       input logic [7:0] wdata);
    mem_req = req; mem_we = we; mem_addr = addr; mem_wdata = wdata;
  endtask

  // Expects exactly 8 edges with mem_ready low after rst falls, then ready.
  task automatic sweep_check(input string tag);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("%s ready low edge %0d", tag, i), mem_ready, 0);
      tick();
      check($sformatf("%s rvalid during sweep %0d", tag, i), mem_rvalid, 0);
      check($sformatf("%s err during sweep %0d", tag, i), mem_err, 0);
    end
    check($sformatf("%s ready after sweep", tag), mem_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Vector table, applied after the first sweep; expected rdata follows the hold rule.
    for (int i = 0; i < 8; i++) add(1, 0, 8'(i), 8'h00, 1, 0, 8'h00);
    add(1, 1, 8'h00, 8'h0A, 0, 0, 8'h00);
    add(1, 1, 8'h01, 8'hFF, 0, 0, 8'h00);
    add(1, 1, 8'h02, 8'h01, 0, 0, 8'h00);
    add(1, 1, 8'h03, 8'h01, 0, 0, 8'h00);
    add(1, 0, 8'h01, 8'h00, 1, 0, 8'hFF);
    add(0, 0, 8'h00, 8'h00, 0, 0, 8'hFF);
    add(1, 1, 8'h05, 8'h55, 0, 0, 8'hFF);
    add(1, 0, 8'h05, 8'h00, 1, 0, 8'h55);
    add(1, 1, 8'h08, 8'h77, 0, 1, 8'h55);
    add(1, 0, 8'h00, 8'h00, 1, 0, 8'h0A);
    add(1, 0, 8'hF3, 8'h00, 1, 1, 8'h00);
    for (int i = 0; i < 8; i++) add(1, 1, 8'(i), 8'(i * 8'h11), 0, 0, 8'h00);
    for (int i = 0; i < 8; i++) add(1, 0, 8'(i), 8'h00, 1, 0, 8'(i * 8'h11));

    // Reset state.
    tick();
    tick();
    check("reset ready", mem_ready, 0);
    check("reset rvalid", mem_rvalid, 0);
    check("reset err", mem_err, 0);
    check("reset rdata", mem_rdata, 0);

    // Sweep with a write to 2 held during it; it must be ignored.
    rst = 1'b0;
    drive(1, 1, 8'h02, 8'h99);
    sweep_check("sweep1");
    drive(0, 0, 8'h00, 8'h00);

    for (int i = 0; i < vecs.size(); i++) begin
      check($sformatf("vec%0d ready", i), mem_ready, 1);
      drive(vecs[i].req, vecs[i].we, vecs[i].addr, vecs[i].wdata);
      tick();
      check($sformatf("vec%0d rvalid", i), mem_rvalid, vecs[i].rvalid);
      check($sformatf("vec%0d err", i), mem_err, vecs[i].err);
      check($sformatf("vec%0d rdata", i), mem_rdata, vecs[i].rdata);
    end
    drive(0, 0, 8'h00, 8'h00);
    tick();
    check("rvalid one-cycle pulse", mem_rvalid, 0);
    check("rdata held when idle", mem_rdata, 8'h77);

    // Reset mid-sweep: pulse rst after 4 sweep edges, then a full sweep follows.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("mid-sweep ready low", mem_ready, 0);
    rst = 1'b1;
    tick();
    check("mid-sweep reset ready", mem_ready, 0);
    rst = 1'b0;
    sweep_check("sweep2");

    // Sweep zeroed the earlier 0x11 pattern.
    drive(1, 0, 8'h01, 8'h00);
    tick();
    check("post-sweep read rvalid", mem_rvalid, 1);
    check("post-sweep read rdata", mem_rdata, 8'h00);

    // Reset on the edge a read would be accepted: no response.
    drive(1, 1, 8'h03, 8'h3C);
    tick();
    drive(1, 0, 8'h03, 8'h00);
    tick();
    check("pre-reset read rdata", mem_rdata, 8'h3C);
    check("pre-reset read rvalid", mem_rvalid, 1);
    rst = 1'b1;
    tick();
    check("reset drops rvalid", mem_rvalid, 0);
    check("reset clears rdata", mem_rdata, 8'h00);
    check("reset ready low", mem_ready, 0);
    drive(0, 0, 8'h00, 8'h00);
    rst = 1'b0;
    tick();
    check("no late rvalid", mem_rvalid, 0);

    // Bounded wait for ready after the third sweep.
    begin
      int cyc = 0;
      while (!mem_ready && cyc < 20) begin
        tick();
        cyc++;
      end
      check("ready within bound", mem_ready, 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
